// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit sitting right after the ALU of the RV32I core.
// It takes the ALU result as the effective address and runs one data-memory
// access over a valid/ready bus. Load data is aligned and extended, store
// byte strobes are generated, and the core is stalled until the access ends.
// Misaligned addresses, illegal funct3 codes and bus timeouts are flagged.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   req_*, alu_addr,  request from the core (held while stall=1)
//   store_data
//   stall             combinational pipeline hold
//   done              one-cycle completion pulse (result/flags valid)
//   load_data,        result and abort flags, held until next completion
//   misaligned,
//   bus_err
//   mem_*             data-memory valid/ready bus
module lsu_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] alu_addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] load_data_q, load_data_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  // request decode
  logic        illegal, misal;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  // loads reject 011/110/111, stores anything above SW
  assign illegal = req_we ? (req_funct3 >= 3'b011)
                          : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  // funct3[1:0] encodes size: 00 byte, 01 half, 10 word
  assign misal = (req_funct3[1:0] == 2'b01 && alu_addr[0]) ||
                 (req_funct3[1:0] == 2'b10 && alu_addr[1:0] != 2'b00);

  always_comb begin
    st_strb  = 4'b1111;
    st_wdata = store_data;
    case (req_funct3[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << alu_addr[1:0];
        st_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        st_strb  = alu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // load extraction uses the access attributes latched in IDLE
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign ld_byte = 8'(mem_rdata >> {alo_q, 3'b000});
  assign ld_half = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    load_data_d = load_data_q;
    mis_d       = mis_q;
    berr_d      = berr_q;

    case (state_q)
      IDLE: if (req_valid) begin
        we_d  = req_we;
        f3_d  = req_funct3;
        alo_d = alu_addr[1:0];
        if (illegal) begin
          // illegal funct3 wins over misalignment: the size is meaningless
          state_d = RESP;
          berr_d  = 1'b1;
          mis_d   = 1'b0;
        end else if (misal) begin
          state_d = RESP;
          mis_d   = 1'b1;
          berr_d  = 1'b0;
        end else begin
          state_d     = REQ;
          cnt_d       = '0;
          mem_req_d   = 1'b1;
          mem_we_d    = req_we;
          mem_addr_d  = {alu_addr[31:2], 2'b00};
          mem_wdata_d = req_we ? st_wdata : 32'd0;
          mem_wstrb_d = req_we ? st_strb : 4'b0000;
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mis_d     = 1'b0;
          berr_d    = 1'b0;
          if (!we_q) load_data_d = ld_ext;
        end else begin
          cnt_d = cnt_q + 10'd1;
          // counter reaching TIMEOUT means TIMEOUT unanswered REQ cycles
          if (cnt_d == 10'(TIMEOUT)) begin
            state_d     = RESP;
            mem_req_d   = 1'b0;
            berr_d      = 1'b1;
            mis_d       = 1'b0;
            load_data_d = 32'd0;
          end
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      alo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      load_data_q <= load_data_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
    end
  end

  assign stall      = (state_q == IDLE && req_valid) || state_q == REQ;
  assign done       = (state_q == RESP);
  assign load_data  = load_data_q;
  assign misaligned = mis_q;
  assign bus_err    = berr_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

endmodule
